// File: rtl/mc14500b_icu.sv
// MC14500B-style 1-bit industrial control unit: one 4-bit instruction per enabled clock.
// Define MC14500B_ICU_STATUS_EN to expose ien_q/oen_q/skip_q for a debug/LED panel.
module mc14500b_icu (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic [3:0] instr,
   input  logic       data_in,
   output logic       data_out,
   output logic       write,
   output logic       rr,
   output logic       jmp,
   output logic       rtn,
   output logic       flag_o,
   output logic       flag_f
`ifdef MC14500B_ICU_STATUS_EN
   ,
   output logic       ien_q,
   output logic       oen_q,
   output logic       skip_q
`endif
);

   typedef enum logic [3:0] {
      OP_NOPO = 4'h0, OP_LD   = 4'h1, OP_LDC  = 4'h2, OP_AND  = 4'h3,
      OP_ANDC = 4'h4, OP_OR   = 4'h5, OP_ORC  = 4'h6, OP_XNOR = 4'h7,
      OP_STO  = 4'h8, OP_STOC = 4'h9, OP_IEN  = 4'hA, OP_OEN  = 4'hB,
      OP_JMP  = 4'hC, OP_RTN  = 4'hD, OP_SKZ  = 4'hE, OP_NOPF = 4'hF
   } opcode_e;

`ifndef MC14500B_ICU_STATUS_EN
   logic ien_q, oen_q, skip_q;
`endif

   logic    rr_q, data_out_q, write_q, jmp_q, rtn_q, flag_o_q, flag_f_q;
   logic    rr_d, data_out_d, write_d, jmp_d, rtn_d, flag_o_d, flag_f_d;
   logic    ien_d, oen_d, skip_d;
   logic    d_eff;
   opcode_e op;

   assign d_eff = data_in & ien_q;
   assign op    = opcode_e'(instr);

   always_comb begin
      rr_d       = rr_q;
      ien_d      = ien_q;
      oen_d      = oen_q;
      skip_d     = skip_q;
      data_out_d = data_out_q;
      write_d    = 1'b0;
      jmp_d      = 1'b0;
      rtn_d      = 1'b0;
      flag_o_d   = 1'b0;
      flag_f_d   = 1'b0;
      if (enable) begin
         // A pending skip consumes this instruction entirely, including SKZ/RTN.
         if (skip_q) begin
            skip_d = 1'b0;
         end else begin
            unique case (op)
               OP_NOPO: flag_o_d = 1'b1;
               OP_LD:   rr_d = d_eff;
               OP_LDC:  rr_d = ~d_eff;
               OP_AND:  rr_d = rr_q & d_eff;
               OP_ANDC: rr_d = rr_q & ~d_eff;
               OP_OR:   rr_d = rr_q | d_eff;
               OP_ORC:  rr_d = rr_q | ~d_eff;
               OP_XNOR: rr_d = ~(rr_q ^ d_eff);
               OP_STO: begin
                  if (oen_q) begin
                     data_out_d = rr_q;
                     write_d    = 1'b1;
                  end
               end
               OP_STOC: begin
                  if (oen_q) begin
                     data_out_d = ~rr_q;
                     write_d    = 1'b1;
                  end
               end
               OP_IEN:  ien_d = data_in;
               OP_OEN:  oen_d = data_in;
               OP_JMP:  jmp_d = 1'b1;
               OP_RTN: begin
                  rtn_d  = 1'b1;
                  skip_d = 1'b1;
               end
               OP_SKZ:  skip_d = ~rr_q;
               OP_NOPF: flag_f_d = 1'b1;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rr_q       <= 1'b0;
         ien_q      <= 1'b0;
         oen_q      <= 1'b0;
         skip_q     <= 1'b0;
         data_out_q <= 1'b0;
         write_q    <= 1'b0;
         jmp_q      <= 1'b0;
         rtn_q      <= 1'b0;
         flag_o_q   <= 1'b0;
         flag_f_q   <= 1'b0;
      end else begin
         rr_q       <= rr_d;
         ien_q      <= ien_d;
         oen_q      <= oen_d;
         skip_q     <= skip_d;
         data_out_q <= data_out_d;
         write_q    <= write_d;
         jmp_q      <= jmp_d;
         rtn_q      <= rtn_d;
         flag_o_q   <= flag_o_d;
         flag_f_q   <= flag_f_d;
      end
   end

   assign rr       = rr_q;
   assign data_out = data_out_q;
   assign write    = write_q;
   assign jmp      = jmp_q;
   assign rtn      = rtn_q;
   assign flag_o   = flag_o_q;
   assign flag_f   = flag_f_q;

endmodule
